equation1_generator: RTL and testbench
======================================

Name: equation1_generator

Overview:
- Puzzle-side producer for the equation-1 alarm challenge. Given a target value (the ongoing timer), it searches for operands X, Y, Z such that the equation checker's 8-bit arithmetic Y/Z + (X/Z)*(X/Z) equals the target.
- Supplies the operand set the checker later validates, for display by the VGA layer.
- Pseudo-random search driven by a free-running LFSR, with a deterministic fallback when the retry budget is exhausted.

Parameters:
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
- MAX_TRIES, 16, candidate attempts before fallback; 0 means immediate fallback.

Ports:
- Clock  in  1  system clock, posedge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  request a new operand set; sampled only in IDLE.
- target  in  7  target value A; latched on accepted start.
- busy  out  1  high whenever state != IDLE.
- ans_valid  out  1  operand set available.
- ans_ready  in  1  consumer accepts the operand set.
- x_out  out  8  operand X.
- y_out  out  8  operand Y.
- z_out  out  8  operand Z, nonzero.
- fallback  out  1  current set is the deterministic fallback.

Behaviour:
- Reset (async): state=IDLE; x_out, y_out, z_out, ans_valid, fallback, try counter and target register = 0; LFSR = LFSR_SEED. Reset mid-search or mid-PRESENT aborts immediately and drops ans_valid.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every clock regardless of state.

States:
- IDLE: on start=1, latch A={1'b0,target} and clear the try counter. Go to PICK, or to FALLBACK if MAX_TRIES==0.
- PICK: snapshot LFSR fields:
  - z = lfsr[2:0]+1 (range 1..8)
  - q = lfsr[6:3] (range 0..15)
  - rx = lfsr[9:7]; replaced by 0 if rx >= z
  - ry = lfsr[12:10]; replaced by 0 if ry >= z
  - Go to BUILD.
- BUILD: if q*q > A, reject. Otherwise compute in 11 bits: x = q*z + rx, y = (A - q*q)*z + ry. If y > 255, reject; else go to VERIFY.
- VERIFY: recompute with the checker's exact 8-bit semantics: integer divides, product truncated to 8 bits, sum truncated to 8 bits. Compare to A. Match: load x_out/y_out/z_out, fallback=0, go to PRESENT. Mismatch: reject.
- Reject (from BUILD or VERIFY): increment the try counter. If it reaches MAX_TRIES, go to FALLBACK; else go to PICK.
- FALLBACK: x_out=0, y_out=A, z_out=1, fallback=1, go to PRESENT.
- PRESENT: ans_valid=1.
  - Outputs held stable while ans_valid && !ans_ready.
  - Transfer occurs at a posedge with ans_valid && ans_ready; the next state is IDLE and ans_valid=0.
  - x/y/z_out retain their values after the transfer.

Timing and ignored inputs:
- Latency: start sampled at edge k; ans_valid=1 after edge k+4 on first-try success; after edge k+2 with MAX_TRIES=0. Each reject adds 2–3 cycles.
- ans_ready=1 when presented gives a single-cycle ans_valid pulse.
- start is ignored outside IDLE, including during PRESENT and in the handshake cycle.
- target changes after latch are ignored.

Boundary:
- A=0: only q=0 can pass.
- A=127: y overflow rejections are frequent; fallback is permitted.
- All outputs are registers; no combinational path from inputs to outputs.

Optional Feature:
- Macro: EQGEN_NONTRIVIAL_EN.
- Defined: BUILD additionally rejects candidates with q==0 or z==1, so presented puzzles need real division and squaring. FALLBACK is unchanged and remains the only source of z=1.
- Undefined: no extra rejection.

Test Plan:
- Reset mid-BUILD with start=1, target=50 held: all outputs 0 and busy=0 immediately; after release, a fresh search starts and ans_valid rises 4+ cycles later.
- target=37, start pulse, ans_ready=1: ans_valid pulses one cycle; y/z + (x/z)^2 (8-bit) == 37; z in 1..8.
- MAX_TRIES=0, target=99: ans_valid after 2 edges with x=0, y=99, z=1, fallback=1.
- target=0, ans_ready=0 for 10 cycles then 1: q=0 and x,y < z; x/y/z held constant while stalled; ans_valid drops the cycle after acceptance; start asserted in the handshake cycle is ignored.
- 500 random targets 0..127 with random ans_ready backpressure: every set satisfies the checker equation; fallback sets are exactly (0, A, 1).
- EQGEN_NONTRIVIAL_EN defined, targets 1..127: every non-fallback set has z >= 2 and x >= z.

Source files
------------

// File: rtl/equation1_generator_if.sv
// Operand-request / operand-delivery bundle between the puzzle logic and the
// equation-1 generator. The slave modport is the generator side.
interface equation1_generator_if;
  logic       start;
  logic [6:0] target;
  logic       busy;
  logic       ans_valid;
  logic       ans_ready;
  logic [7:0] x_out;
  logic [7:0] y_out;
  logic [7:0] z_out;
  logic       fallback;

  modport master (
    output start, target, ans_ready,
    input  busy, ans_valid, x_out, y_out, z_out, fallback
  );

  modport slave (
    input  start, target, ans_ready,
    output busy, ans_valid, x_out, y_out, z_out, fallback
  );
endinterface

// File: rtl/equation1_generator.sv
// Searches LFSR-driven operands X,Y,Z with 8-bit Y/Z + (X/Z)^2 == target, falling
// back to (0, A, 1) after MAX_TRIES rejects. Optional macro: EQGEN_NONTRIVIAL_EN.
module equation1_generator #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_TRIES = 16
) (
  input logic                   Clock,
  input logic                   Reset,
  equation1_generator_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PICK     = 3'd1,
    BUILD    = 3'd2,
    VERIFY   = 3'd3,
    FALLBACK = 3'd4,
    PRESENT  = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;
  logic [15:0] tries;
  logic [15:0] tries_inc;
  logic        tries_last;
  logic [7:0]  a_reg;
  logic        busy_q;
  logic        valid_q;
  logic        fb_q;
  logic [7:0]  x_q;
  logic [7:0]  y_q;
  logic [7:0]  z_q;
  logic        reject;

  // candidate fields snapped in PICK
  logic [3:0]  pick_z;
  logic [2:0]  pick_rx;
  logic [2:0]  pick_ry;
  logic [3:0]  z_p0;
  logic [3:0]  q_p0;
  logic [2:0]  rx_p0;
  logic [2:0]  ry_p0;

  // operands built in BUILD
  logic [7:0]  qq;
  logic [7:0]  x_calc;
  logic [10:0] y_calc;
  logic        build_ok;
  logic [7:0]  x_p1;
  logic [7:0]  y_p1;
  logic        verify_ok;

  // Mirrors the checker: integer divides, 8-bit square, 8-bit sum.
  function automatic logic [7:0] checker_sum(input logic [7:0] x, input logic [7:0] y,
                                             input logic [3:0] z);
    logic [7:0]  zd;
    logic [7:0]  qx;
    logic [7:0]  qy;
    logic [15:0] sq;
    zd = {4'd0, z};
    qx = x / zd;
    qy = y / zd;
    sq = {8'd0, qx} * {8'd0, qx};
    return qy + sq[7:0];
  endfunction

  assign lfsr_nxt   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign tries_inc  = tries + 16'd1;
  assign tries_last = (tries_inc == 16'(MAX_TRIES));

  assign pick_z  = {1'b0, lfsr[2:0]} + 4'd1;
  assign pick_rx = ({1'b0, lfsr[9:7]}   >= pick_z) ? 3'd0 : lfsr[9:7];
  assign pick_ry = ({1'b0, lfsr[12:10]} >= pick_z) ? 3'd0 : lfsr[12:10];

  always_comb begin
    qq       = {4'd0, q_p0} * {4'd0, q_p0};
    x_calc   = {4'd0, q_p0} * {4'd0, z_p0} + {5'd0, rx_p0};
    y_calc   = ({3'd0, a_reg} - {3'd0, qq}) * {7'd0, z_p0} + {8'd0, ry_p0};
    build_ok = (qq <= a_reg) && (y_calc <= 11'd255);
`ifdef EQGEN_NONTRIVIAL_EN
    build_ok = build_ok && (q_p0 != 4'd0) && (z_p0 != 4'd1);
`endif
    verify_ok = (checker_sum(x_p1, y_p1, z_p0) == a_reg);
  end

  always_comb begin
    state_nxt = state;
    reject    = 1'b0;
    case (state)
      IDLE:     if (bus.start) state_nxt = (MAX_TRIES == 0) ? FALLBACK : PICK;
      PICK:     state_nxt = BUILD;
      BUILD:    if (build_ok) state_nxt = VERIFY; else reject = 1'b1;
      VERIFY:   if (verify_ok) state_nxt = PRESENT; else reject = 1'b1;
      FALLBACK: state_nxt = PRESENT;
      PRESENT:  if (valid_q && bus.ans_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (reject) state_nxt = tries_last ? FALLBACK : PICK;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      lfsr    <= LFSR_SEED;
      tries   <= 16'd0;
      a_reg   <= 8'd0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      fb_q    <= 1'b0;
      x_q     <= 8'd0;
      y_q     <= 8'd0;
      z_q     <= 8'd0;
    end else begin
      state  <= state_nxt;
      lfsr   <= lfsr_nxt;
      busy_q <= (state_nxt != IDLE);
      if (state == IDLE && bus.start) begin
        a_reg <= {1'b0, bus.target};
        tries <= 16'd0;
      end
      if (reject) tries <= tries_inc;
      if (state == VERIFY && verify_ok) begin
        x_q  <= x_p1;
        y_q  <= y_p1;
        z_q  <= {4'd0, z_p0};
        fb_q <= 1'b0;
      end
      if (state == FALLBACK) begin
        x_q  <= 8'd0;
        y_q  <= a_reg;
        z_q  <= 8'd1;
        fb_q <= 1'b1;
      end
      // valid rises one cycle after entering PRESENT and falls on transfer
      if (state == PRESENT) valid_q <= !(valid_q && bus.ans_ready);
      else                  valid_q <= 1'b0;
    end
  end

  // ---- stage p0: candidate snapshot / stage p1: built operands ----
  always_ff @(posedge Clock) begin
    if (state == PICK) begin
      z_p0  <= pick_z;
      q_p0  <= lfsr[6:3];
      rx_p0 <= pick_rx;
      ry_p0 <= pick_ry;
    end
    if (state == BUILD) begin
      x_p1 <= x_calc;
      y_p1 <= y_calc[7:0];
    end
  end

  assign bus.busy      = busy_q;
  assign bus.ans_valid = valid_q;
  assign bus.x_out     = x_q;
  assign bus.y_out     = y_q;
  assign bus.z_out     = z_q;
  assign bus.fallback  = fb_q;

endmodule

// File: tb/tb_equation1_generator.sv
// Bench for equation1_generator: fallback vector table on a MAX_TRIES=0 instance,
// directed corner sequences and randomized transactions against a search model.
module tb_equation1_generator;

  localparam int MAX_TRIES = 16;

  logic Clock;
  logic Reset;
  int   checks;
  int   errors;
  bit   abort_run;

  equation1_generator_if bus ();
  equation1_generator_if bus0 ();

  equation1_generator dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  equation1_generator #(.MAX_TRIES(0)) dut0 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus0.slave)
  );

  always #5 Clock = ~Clock;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l, input int n);
    logic [15:0] r;
    r = l;
    for (int i = 0; i < n; i++) r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
    return r;
  endfunction

  // free-running reference LFSR, same reset behaviour as the generator's
  logic [15:0] m_lfsr;
  always @(posedge Clock or posedge Reset) begin
    if (Reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= lfsr_adv(m_lfsr, 1);
  end

  function automatic int eq8(input int x, input int y, input int z);
    int d;
    if (z == 0) return -1;
    d = x / z;
    return ((y / z) + ((d * d) & 255)) & 255;
  endfunction

  // Walk the search attempt by attempt from the LFSR value seen at the first PICK.
  task automatic predict(input logic [15:0] l0, input int a,
                         output int ex, output int ey, output int ez,
                         output int efb, output int elat);
    logic [15:0] l;
    int cyc, z, q, rx, ry, x, y;
    bit ok;
    l = l0; cyc = 0;
    ex = 0; ey = a; ez = 1; efb = 1; elat = -1;
    for (int t = 0; t < MAX_TRIES; t++) begin
      z  = l[2:0] + 1;
      q  = l[6:3];
      rx = l[9:7];
      ry = l[12:10];
      if (rx >= z) rx = 0;
      if (ry >= z) ry = 0;
      ok = (q * q <= a);
`ifdef EQGEN_NONTRIVIAL_EN
      ok = ok && (q != 0) && (z != 1);
`endif
      x = q * z + rx;
      y = (a - q * q) * z + ry;
      if (ok && y > 255) ok = 0;
      if (!ok) begin
        cyc += 2; l = lfsr_adv(l, 2);
        continue;
      end
      if (eq8(x, y, z) != a) begin
        cyc += 3; l = lfsr_adv(l, 3);
        continue;
      end
      ex = x; ey = y; ez = z; efb = 0; elat = cyc + 4;
      return;
    end
    elat = cyc + 2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_set(input int a, input int ex, input int ey, input int ez, input int efb);
    chk("x_out", bus.x_out, ex);
    chk("y_out", bus.y_out, ey);
    chk("z_out", bus.z_out, ez);
    chk("fallback", bus.fallback, efb);
    chk("checker_eq", eq8(bus.x_out, bus.y_out, bus.z_out), a);
    chk("z_range", (bus.z_out >= 1 && bus.z_out <= 8), 1);
    if (bus.fallback)
      chk("fallback_form", {bus.x_out, bus.y_out, bus.z_out}, {8'd0, 8'(a), 8'd1});
`ifdef EQGEN_NONTRIVIAL_EN
    else
      chk("nontrivial", (bus.z_out >= 2 && bus.x_out >= bus.z_out), 1);
`endif
    if (a == 0)
      chk("a0_small", (bus.x_out < bus.z_out && bus.y_out < bus.z_out), 1);
  endtask

  // One full request. When pre_driven, start/target are already applied.
  task automatic do_txn(input logic [6:0] a, input int stall, input bit early,
                        input bit hs_start, input bit pre_driven);
    logic [15:0] l0;
    int ex, ey, ez, efb, elat, n;
    logic [23:0] held;
    if (!pre_driven) begin
      @(negedge Clock);
      bus.target = a; bus.start = 1'b1;
    end
    bus.ans_ready = early;
    @(posedge Clock); #1;
    l0 = m_lfsr;
    chk("accept_busy", bus.busy, 1);
    predict(l0, int'(a), ex, ey, ez, efb, elat);
    @(negedge Clock);
    bus.start = 1'b0;
    bus.target = 7'($urandom);
    n = 0;
    while (bus.ans_valid !== 1'b1 && n < 400) begin
      @(posedge Clock); #1; n++;
    end
    if (bus.ans_valid !== 1'b1) begin
      errors++; checks++;
      $display("FAIL valid_timeout: got no ans_valid after %0d cycles, required %0d", n, elat);
      abort_run = 1;
      return;
    end
    chk("latency", n, elat);
    if (pre_driven) chk("latency_min4", (n >= 4), 1);
    check_set(int'(a), ex, ey, ez, efb);
    held = {bus.x_out, bus.y_out, bus.z_out};
    if (early) begin
      @(posedge Clock); #1;
      chk("pulse_drop", bus.ans_valid, 0);
      chk("idle_after", bus.busy, 0);
      @(negedge Clock);
      bus.ans_ready = 1'b0;
    end else begin
      for (int i = 0; i < stall; i++) begin
        @(posedge Clock); #1;
        chk("stall_valid", bus.ans_valid, 1);
        chk("stall_hold", {bus.x_out, bus.y_out, bus.z_out}, held);
      end
      @(negedge Clock);
      bus.ans_ready = 1'b1;
      bus.start = hs_start;
      bus.target = 7'($urandom);
      @(posedge Clock); #1;
      chk("hs_drop", bus.ans_valid, 0);
      @(negedge Clock);
      bus.ans_ready = 1'b0;
      bus.start = 1'b0;
      chk("retain", {bus.x_out, bus.y_out, bus.z_out}, held);
      @(posedge Clock); #1;
      chk("hs_start_ignored", bus.busy, 0);
    end
  endtask

  typedef struct {
    logic [6:0] tgt;
    logic [7:0] ex;
    logic [7:0] ey;
    logic [7:0] ez;
    logic       efb;
  } fb_vec_t;

  typedef struct {
    logic [6:0] tgt;
    int         stall;
    bit         early;
    bit         hs_start;
  } txn_vec_t;

  fb_vec_t  fbv[4];
  txn_vec_t tv[5];

  initial begin
    checks = 0; errors = 0; abort_run = 0;
    Clock = 0; Reset = 0;
    bus.start = 0; bus.target = 0; bus.ans_ready = 0;
    bus0.start = 0; bus0.target = 0; bus0.ans_ready = 0;

    fbv[0] = '{7'd99,  8'd0, 8'd99,  8'd1, 1'b1};
    fbv[1] = '{7'd0,   8'd0, 8'd0,   8'd1, 1'b1};
    fbv[2] = '{7'd127, 8'd0, 8'd127, 8'd1, 1'b1};
    fbv[3] = '{7'd37,  8'd0, 8'd37,  8'd1, 1'b1};

    tv[0] = '{7'd37,  0,  1'b1, 1'b0};
    tv[1] = '{7'd0,   10, 1'b0, 1'b1};
    tv[2] = '{7'd127, 2,  1'b0, 1'b0};
    tv[3] = '{7'd1,   0,  1'b0, 1'b1};
    tv[4] = '{7'd64,  3,  1'b1, 1'b0};

    #2 Reset = 1;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.ans_valid, 0);
    chk("rst_xyz", {bus.x_out, bus.y_out, bus.z_out}, 0);
    chk("rst_fallback", bus.fallback, 0);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Reset = 0;

    // Reset in the middle of BUILD with start/target held
    @(negedge Clock);
    bus.target = 7'd50; bus.start = 1'b1;
    @(posedge Clock);
    @(posedge Clock); #1;
    Reset = 1;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_valid", bus.ans_valid, 0);
    chk("midrst_xyz", {bus.x_out, bus.y_out, bus.z_out}, 0);
    chk("midrst_fallback", bus.fallback, 0);
    @(negedge Clock);
    Reset = 0;
    do_txn(7'd50, 1, 1'b0, 1'b0, 1'b1);

    // MAX_TRIES=0 instance: fixed fallback table
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      bus0.target = fbv[i].tgt; bus0.start = 1'b1; bus0.ans_ready = 1'b1;
      @(posedge Clock); #1;
      chk("fb_accept", bus0.busy, 1);
      @(negedge Clock);
      bus0.start = 1'b0;
      bus0.target = 7'($urandom);
      @(posedge Clock); #1;
      chk("fb_valid_k1", bus0.ans_valid, 0);
      @(posedge Clock); #1;
      chk("fb_valid_k2", bus0.ans_valid, 1);
      chk("fb_x", bus0.x_out, fbv[i].ex);
      chk("fb_y", bus0.y_out, fbv[i].ey);
      chk("fb_z", bus0.z_out, fbv[i].ez);
      chk("fb_flag", bus0.fallback, fbv[i].efb);
      @(posedge Clock); #1;
      chk("fb_pulse_drop", bus0.ans_valid, 0);
      chk("fb_idle", bus0.busy, 0);
      @(negedge Clock);
      bus0.ans_ready = 1'b0;
    end

    for (int i = 0; i < 5 && !abort_run; i++)
      do_txn(tv[i].tgt, tv[i].stall, tv[i].early, tv[i].hs_start, 1'b0);

    for (int i = 0; i < 500 && !abort_run; i++) begin
`ifdef EQGEN_NONTRIVIAL_EN
      do_txn(7'($urandom_range(1, 127)), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
`else
      do_txn(7'($urandom_range(0, 127)), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
